// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one logic-analyzer acquisition into a ring RAM.
// Optional macro CAPTURE_TRIG_EDGE_EN adds cfg_edge for edge-qualified triggers.
module capture_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int FACTOR_W = 29
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [FACTOR_W-1:0] cfg_factor,
    input  logic [ADDR_W-1:0]   cfg_post,
    input  logic [DATA_W-1:0]   cfg_trig_mask,
    input  logic [DATA_W-1:0]   cfg_trig_val,
`ifdef CAPTURE_TRIG_EDGE_EN
    input  logic                cfg_edge,
`endif
    input  logic [DATA_W-1:0]   din,
    input  logic                ce,
    output logic [FACTOR_W-1:0] presc_factor,
    output logic                presc_rst,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PRE,
        ARMED,
        POST
    } state_t;

    state_t              state;
    logic                sync_cnt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   pre_cnt;
    logic [ADDR_W-1:0]   post_cnt;
    logic [ADDR_W-1:0]   post_lat;
    logic [ADDR_W-1:0]   pre_n;
    logic [DATA_W-1:0]   mask_lat;
    logic [DATA_W-1:0]   val_lat;
    logic                match;
    logic                hit;
    logic                sampling;
    logic                last_sample;

`ifdef CAPTURE_TRIG_EDGE_EN
    logic                edge_lat;
    logic                prev_match;
    logic                have_prev;
`endif

    // DEPTH-1-post is the bitwise complement of post in ADDR_W bits.
    assign pre_n = ~post_lat;

    // Trigger qualification for the sample presented on this edge.
    always_comb begin
        match = ((din ^ val_lat) & mask_lat) == '0;
`ifdef CAPTURE_TRIG_EDGE_EN
        hit = match && (!edge_lat || (have_prev && !prev_match));
`else
        hit = match;
`endif
    end

    // Sample acceptance and detection of the final write of the capture.
    always_comb begin
        sampling    = ce && (state == PRE || state == ARMED || state == POST);
        last_sample = 1'b0;
        if (ce && state == ARMED && hit && post_lat == '0)
            last_sample = 1'b1;
        if (ce && state == POST && post_cnt == post_lat - 1'b1)
            last_sample = 1'b1;
    end

    // Acquisition FSM with registered RAM write port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            presc_factor <= FACTOR_W'(1);
            presc_rst    <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            trig_addr    <= '0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            sync_cnt     <= 1'b0;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            post_lat     <= '0;
            mask_lat     <= '0;
            val_lat      <= '0;
`ifdef CAPTURE_TRIG_EDGE_EN
            edge_lat     <= 1'b0;
            prev_match   <= 1'b0;
            have_prev    <= 1'b0;
`endif
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            presc_rst <= 1'b1;
            wr_en     <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_en <= sampling;
            done  <= last_sample;
            if (sampling) begin
                wr_data <= din;
                wr_addr <= ptr;
                ptr     <= ptr + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    presc_rst <= 1'b1;
                    if (start && !abort) begin
                        presc_factor <= (cfg_factor == '0) ? FACTOR_W'(1)
                                                           : cfg_factor;
                        post_lat  <= cfg_post;
                        mask_lat  <= cfg_trig_mask;
                        val_lat   <= cfg_trig_val;
                        ptr       <= '0;
                        wr_addr   <= '0;
                        pre_cnt   <= '0;
                        post_cnt  <= '0;
                        sync_cnt  <= 1'b0;
                        triggered <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SYNC;
`ifdef CAPTURE_TRIG_EDGE_EN
                        edge_lat   <= cfg_edge;
                        prev_match <= 1'b0;
                        have_prev  <= 1'b0;
`endif
                    end
                end
                SYNC: begin
                    sync_cnt <= ~sync_cnt;
                    if (sync_cnt) begin
                        presc_rst <= 1'b0;
                        state     <= (pre_n == '0) ? ARMED : PRE;
                    end
                end
                PRE: begin
                    if (ce) begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt == pre_n - 1'b1)
                            state <= ARMED;
                    end
                end
                ARMED: begin
                    if (ce) begin
`ifdef CAPTURE_TRIG_EDGE_EN
                        prev_match <= match;
                        have_prev  <= 1'b1;
`endif
                        if (hit) begin
                            trig_addr <= ptr;
                            triggered <= 1'b1;
                            post_cnt  <= '0;
                            state     <= POST;
                        end
                    end
                end
                POST: begin
                    if (ce)
                        post_cnt <= post_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (last_sample) begin
                state     <= IDLE;
                busy      <= 1'b0;
                presc_rst <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Testbench for capture_sequencer: prescaler stand-in, write monitor and
// a behavioural acquisition model computed from the sample stream.
`timescale 1ns/1ps
module tb_capture_sequencer;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int FW    = 29;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] cfg_factor = FW'(1);
    logic [AW-1:0] cfg_post = '0;
    logic [DW-1:0] cfg_trig_mask = '0;
    logic [DW-1:0] cfg_trig_val = '0;
`ifdef CAPTURE_TRIG_EDGE_EN
    logic          cfg_edge = 1'b0;
`endif
    logic [DW-1:0] din = '0;
    logic          ce;
    logic          noise = 1'b0;
    logic          pce = 1'b0;
    int            pcnt = 0;

    logic [FW-1:0] presc_factor;
    logic          presc_rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          triggered;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] s_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            done_n = 0;
    int            done_at = -1;
    bit            done_we = 1'b0;
    int            edge_k = 0;
    logic [DW-1:0] edge_val = '0;

    capture_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .FACTOR_W (FW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_factor    (cfg_factor),
        .cfg_post      (cfg_post),
        .cfg_trig_mask (cfg_trig_mask),
        .cfg_trig_val  (cfg_trig_val),
`ifdef CAPTURE_TRIG_EDGE_EN
        .cfg_edge      (cfg_edge),
`endif
        .din           (din),
        .ce            (ce),
        .presc_factor  (presc_factor),
        .presc_rst     (presc_rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .trig_addr     (trig_addr),
        .busy          (busy),
        .triggered     (triggered),
        .done          (done)
    );

    always #5 clk = ~clk;

    assign ce = pce | noise;

    // Stand-in for the prescaler: one ce every presc_factor cycles.
    always @(posedge clk) begin
        if (presc_rst) begin
            pcnt <= 0;
            pce  <= 1'b0;
        end else if (pcnt >= int'(presc_factor) - 1) begin
            pcnt <= 0;
            pce  <= 1'b1;
        end else begin
            pcnt <= pcnt + 1;
            pce  <= 1'b0;
        end
    end

    // Record RAM writes, done pulses and the samples presented on ce.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done) begin
            done_n  = done_n + 1;
            done_at = wa_q.size();
            done_we = wr_en;
        end
        if (pce)
            s_q.push_back(din);
    end

    // Expected write count: trigger is the first qualifying sample after
    // the pre-trigger window, followed by post more samples.
    function automatic int model_len(input int post,
                                     input logic [DW-1:0] mask,
                                     input logic [DW-1:0] val,
                                     input bit edge_en,
                                     output int trig);
        int pre_n;
        bit m;
        bit pm;
        pre_n = DEPTH - 1 - post;
        trig  = -1;
        for (int i = pre_n; i < s_q.size(); i++) begin
            m  = ((s_q[i] ^ val) & mask) == '0;
            pm = (i > pre_n) && (((s_q[i-1] ^ val) & mask) == '0);
            if (m && (!edge_en || (i > pre_n && !pm))) begin
                trig = i;
                break;
            end
        end
        return (trig < 0) ? -1 : trig + 1 + post;
    endfunction

    function automatic logic [DW-1:0] next_din(input int mode);
        case (mode)
            0:       return DW'(s_q.size());
            1:       return DW'($urandom);
            default: return (s_q.size() == edge_k) ? '0 : edge_val;
        endcase
    endfunction

    task automatic run_capture(input int mode, input bit disturb,
                               input int budget, input int tail,
                               output bit tmo);
        start = 1'b1;
        din   = next_din(mode);
        @(posedge clk);
        #1;
        start = 1'b0;
        wa_q.delete();
        wd_q.delete();
        s_q.delete();
        done_n  = 0;
        done_at = -1;
        done_we = 1'b0;
        tmo = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
            if (disturb) begin
                start = (c == 4);
                if (c == 4) begin
                    cfg_factor    = FW'($urandom_range(0, 7));
                    cfg_post      = AW'($urandom);
                    cfg_trig_mask = DW'($urandom);
                    cfg_trig_val  = DW'($urandom);
                end
            end
            din = next_din(mode);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (tmo) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        repeat (tail) begin
            din = next_din(mode);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({presc_factor, presc_rst, wr_en, wr_addr, wr_data, trig_addr,
             busy, triggered, done} !==
            {FW'(1), 1'b1, 1'b0, AW'(0), DW'(0), AW'(0), 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got f=%0h pr=%b we=%b a=%h d=%h t=%h b=%b tr=%b dn=%b want f=1 pr=1 rest 0",
                     presc_factor, presc_rst, wr_en, wr_addr, wr_data,
                     trig_addr, busy, triggered, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_ignore();
        wa_q.delete();
        noise = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        noise = 1'b0;
        n_cmp++;
        if (wa_q.size() != 0 || busy !== 1'b0 || presc_rst !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ignore: got writes=%0d busy=%b prst=%b want 0 0 1",
                     wa_q.size(), busy, presc_rst);
        end
    endtask

    task automatic test_normal();
        bit tmo;
        cfg_factor    = FW'(1);
        cfg_post      = AW'(5);
        cfg_trig_mask = 8'hFF;
        cfg_trig_val  = 8'h14;
        run_capture(0, 1'b0, 400, 4, tmo);
        n_cmp++;
        if (tmo || wa_q.size() != 26) begin
            n_err++;
            $display("FAIL normal_len: got %0d tmo=%0d want 26",
                     wa_q.size(), tmo);
        end else begin
            for (int i = 0; i < 26; i++) begin
                n_cmp++;
                if (wa_q[i] !== AW'(i % DEPTH) || wd_q[i] !== DW'(i)) begin
                    n_err++;
                    $display("FAIL normal_wr%0d: got %h/%h want %h/%h", i,
                             wa_q[i], wd_q[i], AW'(i % DEPTH), DW'(i));
                end
            end
        end
        n_cmp++;
        if (trig_addr !== AW'(4) || triggered !== 1'b1) begin
            n_err++;
            $display("FAIL normal_trig: got addr=%h trg=%b want 4 1",
                     trig_addr, triggered);
        end
        n_cmp++;
        if (done_n != 1 || done_at != 26 || !done_we || busy !== 1'b0) begin
            n_err++;
            $display("FAIL normal_done: got n=%0d at=%0d we=%0d busy=%b want 1 26 1 0",
                     done_n, done_at, done_we, busy);
        end
    endtask

    task automatic test_immediate(input int factor);
        bit tmo;
        cfg_factor    = FW'(factor);
        cfg_post      = AW'(15);
        cfg_trig_mask = 8'h00;
        cfg_trig_val  = DW'($urandom);
        run_capture(1, 1'b0, 600, 4, tmo);
        n_cmp++;
        if (tmo || wa_q.size() != 16) begin
            n_err++;
            $display("FAIL imm%0d_len: got %0d tmo=%0d want 16",
                     factor, wa_q.size(), tmo);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== s_q[i]) begin
                    n_err++;
                    $display("FAIL imm%0d_wr%0d: got %h/%h want %h/%h",
                             factor, i, wa_q[i], wd_q[i], AW'(i), s_q[i]);
                end
            end
        end
        n_cmp++;
        if (trig_addr !== AW'(0) || triggered !== 1'b1 || done_n != 1 ||
            done_at != 16) begin
            n_err++;
            $display("FAIL imm%0d_trig: got addr=%h trg=%b done=%0d@%0d want 0 1 1@16",
                     factor, trig_addr, triggered, done_n, done_at);
        end
    endtask

    task automatic test_factor_zero();
        logic [2:0] seq;
        cfg_factor = '0;
        cfg_post   = AW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seq[2] = presc_rst;
        n_cmp++;
        if (presc_factor !== FW'(1) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL factor0: got factor=%0h busy=%b want 1 1",
                     presc_factor, busy);
        end
        @(posedge clk);
        #1;
        seq[1] = presc_rst;
        @(posedge clk);
        #1;
        seq[0] = presc_rst;
        n_cmp++;
        if (seq !== 3'b110) begin
            n_err++;
            $display("FAIL factor0_prst: got %b want 110", seq);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_abort_post();
        int nwr;
        bit seen;
        cfg_factor    = FW'(1);
        cfg_post      = AW'(5);
        cfg_trig_mask = 8'hFF;
        cfg_trig_val  = 8'h14;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wa_q.delete();
        wd_q.delete();
        s_q.delete();
        done_n = 0;
        din = next_din(0);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wa_q.size() >= 23) begin
                seen = 1'b1;
                break;
            end
            din = next_din(0);
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL abort_reach: got %0d writes want 23", wa_q.size());
        end
        abort = 1'b1;
        din   = next_din(0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_cmp++;
        if ({busy, presc_rst, wr_en} !== 3'b010) begin
            n_err++;
            $display("FAIL abort_next: got busy/prst/we=%b want 010",
                     {busy, presc_rst, wr_en});
        end
        nwr = wa_q.size();
        repeat (20) begin
            din = next_din(0);
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (wa_q.size() != nwr || nwr > 25 || done_n != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got writes=%0d->%0d done=%0d want no change, <26, 0",
                     nwr, wa_q.size(), done_n);
        end
        n_cmp++;
        if (triggered !== 1'b1) begin
            n_err++;
            $display("FAIL abort_trig: got %b want 1", triggered);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        cfg_factor    = FW'(1);
        cfg_post      = AW'(5);
        cfg_trig_mask = 8'hFF;
        cfg_trig_val  = 8'hF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wa_q.delete();
        s_q.delete();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wa_q.size() >= 14) begin
                seen = 1'b1;
                break;
            end
            din = next_din(0);
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (!seen ||
            {presc_factor, presc_rst, wr_en, wr_addr, wr_data, trig_addr,
             busy, triggered, done} !==
            {FW'(1), 1'b1, 1'b0, AW'(0), DW'(0), AW'(0), 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst: got seen=%0d f=%0h pr=%b we=%b a=%h d=%h t=%h b=%b tr=%b dn=%b want f=1 pr=1 rest 0",
                     seen, presc_factor, presc_rst, wr_en, wr_addr, wr_data,
                     trig_addr, busy, triggered, done);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int n;
        int trig;
        int post;
        bit tmo;
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        for (int it = 0; it < 6; it++) begin
            post = (it % 2 == 1) ? int'($urandom_range(0, 10))
                                 : int'($urandom_range(0, 15));
            m = DW'($urandom) & DW'($urandom) & 8'h0F;
            v = DW'($urandom);
            cfg_factor    = FW'($urandom_range(1, 3));
            cfg_post      = AW'(post);
            cfg_trig_mask = m;
            cfg_trig_val  = v;
            run_capture(1, it % 2 == 1, 3000, 4, tmo);
            n = model_len(post, m, v, 1'b0, trig);
            n_cmp++;
            if (tmo || n < 0 || wa_q.size() != n) begin
                n_err++;
                $display("FAIL rnd%0d_len: got %0d tmo=%0d want %0d",
                         it, wa_q.size(), tmo, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_cmp++;
                    if (wa_q[i] !== AW'(i % DEPTH) || wd_q[i] !== s_q[i]) begin
                        n_err++;
                        $display("FAIL rnd%0d_wr%0d: got %h/%h want %h/%h",
                                 it, i, wa_q[i], wd_q[i], AW'(i % DEPTH), s_q[i]);
                    end
                end
                n_cmp++;
                if (trig_addr !== AW'(trig % DEPTH) || triggered !== 1'b1 ||
                    done_n != 1 || done_at != n || !done_we) begin
                    n_err++;
                    $display("FAIL rnd%0d_trig: got addr=%h trg=%b done=%0d@%0d want %h 1 1@%0d",
                             it, trig_addr, triggered, done_n, done_at,
                             AW'(trig % DEPTH), n);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int trig;
        int post;
        bit tmo;
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        cfg_factor    = FW'(2);
        cfg_post      = AW'(4);
        cfg_trig_mask = 8'h01;
        cfg_trig_val  = 8'h00;
        run_capture(1, 1'b1, 3000, 0, tmo);
        n_cmp++;
        if (tmo) begin
            n_err++;
            $display("FAIL b2b_first: got timeout want completion");
        end
        post = int'($urandom_range(0, 15));
        m = 8'h03;
        v = DW'($urandom);
        cfg_factor    = FW'(1);
        cfg_post      = AW'(post);
        cfg_trig_mask = m;
        cfg_trig_val  = v;
        run_capture(1, 1'b0, 3000, 4, tmo);
        n = model_len(post, m, v, 1'b0, trig);
        n_cmp++;
        if (tmo || n < 0 || wa_q.size() != n || done_n != 1 ||
            done_at != n || trig_addr !== AW'(trig % DEPTH)) begin
            n_err++;
            $display("FAIL b2b_second: got len=%0d done=%0d@%0d addr=%h want %0d 1@%0d %h",
                     wa_q.size(), done_n, done_at, trig_addr, n, n,
                     AW'(trig % DEPTH));
        end else begin
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (wa_q[i] !== AW'(i % DEPTH) || wd_q[i] !== s_q[i]) begin
                    n_err++;
                    $display("FAIL b2b_wr%0d: got %h/%h want %h/%h", i,
                             wa_q[i], wd_q[i], AW'(i % DEPTH), s_q[i]);
                end
            end
        end
    endtask

`ifdef CAPTURE_TRIG_EDGE_EN
    task automatic test_edge();
        bit tmo;
        edge_k   = 16;
        edge_val = 8'hA5;
        cfg_factor    = FW'(1);
        cfg_post      = AW'(3);
        cfg_trig_mask = 8'hFF;
        cfg_trig_val  = 8'hA5;
        cfg_edge      = 1'b1;
        run_capture(2, 1'b0, 400, 4, tmo);
        cfg_edge = 1'b0;
        n_cmp++;
        if (tmo || wa_q.size() != 21) begin
            n_err++;
            $display("FAIL edge_len: got %0d tmo=%0d want 21",
                     wa_q.size(), tmo);
        end else begin
            for (int i = 0; i < 21; i++) begin
                n_cmp++;
                if (wa_q[i] !== AW'(i % DEPTH) ||
                    wd_q[i] !== ((i == 16) ? 8'h00 : 8'hA5)) begin
                    n_err++;
                    $display("FAIL edge_wr%0d: got %h/%h", i, wa_q[i], wd_q[i]);
                end
            end
        end
        n_cmp++;
        if (trig_addr !== AW'(1) || triggered !== 1'b1 || done_n != 1) begin
            n_err++;
            $display("FAIL edge_trig: got addr=%h trg=%b done=%0d want 1 1 1",
                     trig_addr, triggered, done_n);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ignore();
        test_normal();
        test_immediate(1);
        test_factor_zero();
        test_abort_post();
        test_async_reset();
        test_immediate(2);
        test_random();
        test_back_to_back();
`ifdef CAPTURE_TRIG_EDGE_EN
        test_edge();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one logic-analyzer acquisition.
- Programs the sample-rate prescaler's factor and controls its reset.
- On each prescaler `ce`, writes one channel sample into a circular sample RAM.
- Fills the pre-trigger window, arms the trigger, captures a programmable post-trigger count, then reports completion with the trigger address.
- Sits between the host-side config registers, the prescaler and the sample RAM write port.

Parameters:
- ADDR_W, 10, sample RAM address width; DEPTH = 2^ADDR_W.
- DATA_W, 8, number of probe channels (sample width).
- FACTOR_W, 29, width of the prescaler factor bus.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin acquisition; ignored while busy.
- abort  in  1  cancel acquisition; level, sampled on posedge.
- cfg_factor  in  FACTOR_W  requested prescaler division factor.
- cfg_post  in  ADDR_W  post-trigger sample count.
- cfg_trig_mask  in  DATA_W  channels participating in the trigger.
- cfg_trig_val  in  DATA_W  required levels on masked channels.
- din  in  DATA_W  live probe channels.
- ce  in  1  sample strobe from the prescaler.
- presc_factor  out  FACTOR_W  factor driven to the prescaler.
- presc_rst  out  1  active-high reset to the prescaler.
- wr_en  out  1  sample RAM write enable.
- wr_addr  out  ADDR_W  sample RAM write address.
- wr_data  out  DATA_W  sample RAM write data.
- trig_addr  out  ADDR_W  RAM address holding the trigger sample.
- busy  out  1  acquisition in progress.
- triggered  out  1  trigger seen in the current or last acquisition.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values, asserted asynchronously while `rst` = 0:
  - state = IDLE.
  - presc_factor = 1, presc_rst = 1.
  - wr_en = 0, wr_addr = 0, wr_data = 0, trig_addr = 0.
  - busy = 0, triggered = 0, done = 0.
  - All internal counters = 0.
- States: IDLE, SYNC, PRE, ARMED, POST.
- IDLE:
  - presc_rst = 1.
  - When `start` = 1:
    - latch cfg_factor as presc_factor; a value of 0 is latched as 1;
    - latch cfg_post, mask and value;
    - clear wr_addr, the pre counter and triggered;
    - busy <= 1; go to SYNC.
- SYNC:
  - Lasts exactly 2 cycles with presc_rst = 1 so the prescaler loads the new factor with a cleared counter.
  - Then presc_rst <= 0 and go to PRE.
- Sample event (PRE, ARMED and POST only):
  - On a cycle where `ce` = 1, the next cycle has wr_en = 1 and wr_data = din as registered at that `ce` edge.
  - wr_addr is the current pointer, which then increments modulo DEPTH and wraps with no flag.
  - Write latency is 1 cycle; `ce` outside these states is ignored.
- PRE:
  - PRE_N = DEPTH - 1 - cfg_post.
  - Count PRE_N samples, then go to ARMED.
  - If PRE_N = 0, go to ARMED immediately without consuming a sample.
- ARMED:
  - On each sample, evaluate (din & mask) == (val & mask).
  - On a match: that sample is written, trig_addr <= its address, triggered <= 1.
  - After a match: if cfg_post = 0, finish; else go to POST.
  - mask = 0 therefore triggers on the first armed sample.
- POST: write cfg_post further samples, then finish.
- Finish:
  - done = 1 for 1 cycle, coincident with the last wr_en;
  - busy <= 0, presc_rst <= 1, go to IDLE.
  - trig_addr and triggered hold until the next start.
- abort = 1 in any non-IDLE state:
  - next cycle is IDLE, busy = 0, presc_rst = 1;
  - no done pulse and no further wr_en;
  - triggered keeps its value.
  - abort has priority over a simultaneous `ce` or trigger.
- start while busy is ignored; start and abort together in IDLE stay in IDLE.
- Config inputs may change at any time; only the values latched at start are used.

Optional Feature:
- Macro: `CAPTURE_TRIG_EDGE_EN`.
- When defined:
  - an extra input `cfg_edge` (1 bit) is present and latched at start;
  - if the latched `cfg_edge` = 1, the trigger requires the masked match on the current sample AND a non-match on the previous sample;
  - the first armed sample never edge-triggers.
- When undefined: no `cfg_edge` port; level match only.

Test Plan:
- Normal capture, ADDR_W=4, factor=1, post=5, mask=FF, val=14, din = sample index 0,1,2,…:
  - 26 writes total; samples 0..19 go to addresses 0..19 mod 16;
  - trigger sample 0x14 lands at address 4, trig_addr=4;
  - post samples at addresses 5..9; done pulses with the 26th write.
- Immediate trigger, post=15, mask=00: PRE skipped, trigger at address 0, trig_addr=0, 16 writes, triggered=1.
- Factor 0: cfg_factor=0 -> presc_factor=1; presc_rst high exactly 2 cycles after start.
- Abort in POST after 2 post writes:
  - busy=0 and presc_rst=1 the next cycle;
  - done never pulses; no further wr_en.
- Asynchronous reset, rst=0 mid-ARMED between clock edges: all outputs take reset values immediately; a start after release begins cleanly.
- With `CAPTURE_TRIG_EDGE_EN`, cfg_edge=1, din held at val through arming:
  - no trigger while din stays at val;
  - din -> 00 -> val triggers on the val sample.
